// File: rtl/cs_pkg.sv
// -----------------------------------------------------------------------------
// cs_pkg
// Shared definitions for the CS window filter and its downstream result FIFO.
//   CS_DW       : width of one filter result word
//   CS_WIN      : filter window length; also the number of start-up results
//                 that are not yet meaningful
//   cs_result_t : one filter result word
// -----------------------------------------------------------------------------
package cs_pkg;

    localparam int CS_DW  = 10;
    localparam int CS_WIN = 9;

    typedef logic [CS_DW-1:0] cs_result_t;

endpackage : cs_pkg

// File: rtl/cs_sync_fifo.sv
// -----------------------------------------------------------------------------
// cs_sync_fifo
// Single-clock FIFO with a registered head word and an explicit level count.
//
// Handshake: the head entry is offered on rdata_o whenever valid_o=1; an
// entry is consumed on a rising edge where valid_o=1 and pop_i=1. pop_i while
// empty is ignored. A push is accepted when the FIFO is not full, or when it
// is full and a pop happens on the same edge.
//
// Ports:
//   clk_i    : clock, all state on rising edge
//   rst_i    : asynchronous active-high reset
//   push_i   : write request for wdata_i
//   wdata_i  : data to append at the tail
//   pop_i    : consumer accepts the head entry
//   rdata_o  : head entry (registered, 0 after reset)
//   valid_o  : FIFO holds at least one entry
//   full_o   : FIFO holds DEPTH entries
//   level_o  : entry count, 0..DEPTH
// -----------------------------------------------------------------------------
module cs_sync_fifo
    import cs_pkg::*;
#(
    parameter int DW    = CS_DW,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] head_q, head_d;

    logic empty, full, do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A pop frees the slot the push needs, so full does not block a push then.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;

        // Pointers are PW bits wide and DEPTH is a power of two: natural wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // The head register mirrors the storage slot at the read pointer.
        // The incoming word becomes the head when the FIFO is (or becomes)
        // otherwise empty; after a pop with two or more entries the next
        // stored word moves up. At full, wr_ptr equals rd_ptr, so the slot
        // being overwritten is never the one read here.
        if (do_push && (empty || (do_pop && level_q == LW'(1)))) begin
            head_d = wdata_i;
        end else if (do_pop && level_q >= LW'(2)) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: a slot is always written before it is read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = head_q;
    assign valid_o = !empty;
    assign full_o  = full;
    assign level_o = level_q;

endmodule : cs_sync_fifo

// File: rtl/cs_result_fifo.sv
// -----------------------------------------------------------------------------
// cs_result_fifo
// Downstream stage of the CS window filter. Samples the filter result every
// clock, drops the results produced while the filter window is still filling
// after reset, buffers the rest and hands them to a consumer over valid/ready.
//
// Handshake: out_data is valid while out_valid=1; the entry is consumed on a
// rising edge with out_valid=1 and out_ready=1. While out_valid=1 and
// out_ready=0, out_data and out_valid hold. out_ready while out_valid=0 is
// ignored.
//
// Ports:
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-high reset
//   y_in      : filter result, sampled every rising edge
//   out_data  : FIFO head entry
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts out_data this edge
//   level     : entry count, 0..DEPTH
//   warm      : warm-up complete; samples are being captured
//   overflow  : sticky, at least one capturable sample was dropped
// -----------------------------------------------------------------------------
module cs_result_fifo
    import cs_pkg::*;
#(
    parameter int DW     = CS_DW,
    parameter int DEPTH  = 16,
    parameter int WARMUP = CS_WIN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DW-1:0]            y_in,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     warm,
    output logic                     overflow
);

    localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    // With no warm-up the very first sample after reset is already usable,
    // before the registered warm flag has had an edge to rise.
    localparam bit CAPTURE_FROM_FIRST = (WARMUP == 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;
    logic          warm_q, warm_d;
    logic          ovf_q, ovf_d;

    logic push_req;
    logic fifo_full;
    logic fifo_valid;

    assign cnt_inc  = {1'b0, cnt_q} + (CW + 1)'(1);
    assign push_req = warm_q || CAPTURE_FROM_FIRST;

    always_comb begin
        cnt_d  = cnt_q;
        warm_d = warm_q;
        // The counter stops once warm is set, which makes it saturate.
        if (!warm_q) begin
            cnt_d = cnt_inc[CW-1:0];
            if (cnt_inc >= (CW + 1)'(WARMUP)) warm_d = 1'b1;
        end

        // A capturable sample is lost only when full and nothing leaves.
        ovf_d = ovf_q || (push_req && fifo_full && !(out_ready && fifo_valid));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            warm_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            warm_q <= warm_d;
            ovf_q  <= ovf_d;
        end
    end

    cs_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_req),
        .wdata_i (y_in),
        .pop_i   (out_ready),
        .rdata_o (out_data),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .level_o (level)
    );

    assign out_valid = fifo_valid;
    assign warm      = warm_q;
    assign overflow  = ovf_q;

endmodule : cs_result_fifo
